// File: rtl/platform_rng_pkg.sv
// rtl/platform_rng_pkg.sv - shared state type and LFSR constants for the platform RNG scheduler
package platform_rng_pkg;

    localparam int LFSR_W = 9;
    localparam int TAP_HI = 8;
    localparam int TAP_LO = 4;
    localparam logic [LFSR_W-1:0] LFSR_LOCKUP = 9'h1FF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_STEP  = 2'd1,
        ST_GRANT = 2'd2
    } sched_state_e;

endpackage

// File: rtl/platform_rng_sched_if.sv
// rtl/platform_rng_sched_if.sv - request/grant/random bus; seed_load/seed_in exist only with RNG_RESEED_EN
interface platform_rng_sched_if #(parameter int N_REQ = 4);
    import platform_rng_pkg::*;

    logic              en;
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  gnt;
    logic [LFSR_W-1:0] rand_out;
    logic              rand_valid;
    logic              busy;

`ifdef RNG_RESEED_EN
    logic              seed_load;
    logic [LFSR_W-1:0] seed_in;

    modport master (output en, req, seed_load, seed_in, input gnt, rand_out, rand_valid, busy);
    modport slave  (input en, req, seed_load, seed_in, output gnt, rand_out, rand_valid, busy);
`else
    modport master (output en, req, input gnt, rand_out, rand_valid, busy);
    modport slave  (input en, req, output gnt, rand_out, rand_valid, busy);
`endif

endinterface

// File: rtl/rng_lfsr9.sv
// rtl/rng_lfsr9.sv - 9-bit XNOR LFSR with load port and all-ones lockup recovery to SEED
module rng_lfsr9
    import platform_rng_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = 9'h0A5
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              shift,
    input  logic              load,
    input  logic [LFSR_W-1:0] load_val,
    output logic [LFSR_W-1:0] q
);

    logic [LFSR_W-1:0] q_q, q_d;

    // All-ones is the XNOR lockup state; escape it through SEED instead of shifting
    always_comb begin
        q_d = q_q;
        if (load) begin
            q_d = load_val;
        end else if (shift) begin
            if (q_q == LFSR_LOCKUP) begin
                q_d = SEED;
            end else begin
                q_d = {q_q[LFSR_W-2:0], ~(q_q[TAP_HI] ^ q_q[TAP_LO])};
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/platform_rng_sched.sv
// rtl/platform_rng_sched.sv - round-robin scheduler handing out LFSR values; RNG_RESEED_EN adds seed reload
module platform_rng_sched
    import platform_rng_pkg::*;
#(
    parameter int                N_REQ = 4,
    parameter int                STEPS = 9,
    parameter logic [LFSR_W-1:0] SEED  = 9'h0A5
) (
    input  logic                Clk,
    input  logic                Reset,
    platform_rng_sched_if.slave bus
);

    localparam int                IDX_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int                SUM_W     = IDX_W + 1;
    localparam logic [3:0]        LAST_STEP = 4'(STEPS - 1);
    localparam logic [IDX_W-1:0]  LAST_IDX  = IDX_W'(N_REQ - 1);

    sched_state_e      state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LFSR_W-1:0] rand_q, rand_d;

    logic [LFSR_W-1:0] lfsr;
    logic              lfsr_shift;
    logic              lfsr_load;
    logic [LFSR_W-1:0] lfsr_load_val;
    logic              abort;
    logic              fire;
    logic              rr_hit;
    logic [IDX_W-1:0]  rr_pick;
    logic [SUM_W-1:0]  rr_sum;
    logic [IDX_W-1:0]  rr_idx;
    logic [N_REQ-1:0]  gnt;

`ifdef RNG_RESEED_EN
    assign abort         = bus.seed_load;
    assign lfsr_load     = bus.seed_load;
    assign lfsr_load_val = (bus.seed_in == LFSR_LOCKUP) ? SEED : bus.seed_in;
`else
    assign abort         = 1'b0;
    assign lfsr_load     = 1'b0;
    assign lfsr_load_val = SEED;
`endif

    // First requester at or after rr_ptr, wrapping modulo N_REQ
    always_comb begin
        rr_hit  = 1'b0;
        rr_pick = rr_ptr_q;
        rr_sum  = '0;
        rr_idx  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, rr_ptr_q} + SUM_W'(k);
            if (rr_sum >= SUM_W'(N_REQ)) begin
                rr_sum = rr_sum - SUM_W'(N_REQ);
            end
            rr_idx = rr_sum[IDX_W-1:0];
            if (!rr_hit && bus.req[rr_idx]) begin
                rr_hit  = 1'b1;
                rr_pick = rr_idx;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        win_d      = win_q;
        rr_ptr_d   = rr_ptr_q;
        rand_d     = rand_q;
        lfsr_shift = 1'b0;
        fire       = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
        end else if (bus.en) begin
            case (state_q)
                ST_IDLE: begin
                    if (rr_hit) begin
                        win_d   = rr_pick;
                        cnt_d   = '0;
                        state_d = ST_STEP;
                    end
                end
                ST_STEP: begin
                    lfsr_shift = 1'b1;
                    cnt_d      = cnt_q + 4'd1;
                    if (cnt_q == LAST_STEP) begin
                        state_d = ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    // A winner that withdrew forfeits the slot without moving the pointer
                    if (bus.req[win_q]) begin
                        fire     = 1'b1;
                        rand_d   = lfsr;
                        rr_ptr_d = (win_q == LAST_IDX) ? '0 : win_q + IDX_W'(1);
                    end
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            win_q    <= '0;
            rr_ptr_q <= '0;
            rand_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            win_q    <= win_d;
            rr_ptr_q <= rr_ptr_d;
            rand_q   <= rand_d;
        end
    end

    always_comb begin
        gnt = '0;
        if (fire) begin
            gnt[win_q] = 1'b1;
        end
    end

    assign bus.gnt        = gnt;
    assign bus.rand_valid = fire;
    assign bus.rand_out   = fire ? lfsr : rand_q;
    assign bus.busy       = (state_q != ST_IDLE);

    rng_lfsr9 #(.SEED(SEED)) u_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .shift    (lfsr_shift),
        .load     (lfsr_load),
        .load_val (lfsr_load_val),
        .q        (lfsr)
    );

endmodule

// File: tb/tb_platform_rng_sched.sv
// tb/tb_platform_rng_sched.sv - self-checking bench for platform_rng_sched (reseed sequence under RNG_RESEED_EN)
module tb_platform_rng_sched;

    localparam int         N     = 4;
    localparam int         STEPS = 9;
    localparam logic [8:0] SEED  = 9'h0A5;

    logic Clk   = 1'b0;
    logic Reset = 1'b1;
    always #5 Clk = ~Clk;

    platform_rng_sched_if #(.N_REQ(N)) bus ();

    platform_rng_sched #(.N_REQ(N), .STEPS(STEPS), .SEED(SEED)) dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus)
    );

    logic       l_shift = 1'b0;
    logic       l_load  = 1'b0;
    logic [8:0] l_val   = '0;
    logic [8:0] l_q;

    rng_lfsr9 #(.SEED(SEED)) u_ref_lfsr (
        .Clk      (Clk),
        .Reset    (Reset),
        .shift    (l_shift),
        .load     (l_load),
        .load_val (l_val),
        .q        (l_q)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference model: an arbitration opens a window of STEPS+1 enabled cycles, the last being the grant slot
    int         m_left;
    int         m_win;
    int         m_rr;
    logic [8:0] m_lfsr;
    logic [8:0] m_last;

    function automatic logic [8:0] lfsr_next(input logic [8:0] v);
        if (v == 9'h1FF) return SEED;
        return {v[7:0], ~(v[8] ^ v[4])};
    endfunction

    function automatic logic [8:0] lfsr_adv(input logic [8:0] v, input int n);
        logic [8:0] r = v;
        for (int i = 0; i < n; i++) r = lfsr_next(r);
        return r;
    endfunction

    task automatic model_reset();
        m_left = 0;
        m_win  = 0;
        m_rr   = 0;
        m_lfsr = SEED;
        m_last = '0;
    endtask

    function automatic logic [3:0] model_gnt();
        logic [3:0] g = '0;
        if (bus.en && m_left == 1 && bus.req[m_win]) g[m_win] = 1'b1;
        return g;
    endfunction

    task automatic model_clock();
        if (!bus.en) return;
        if (m_left == 0) begin
            for (int k = 0; k < N; k++) begin
                if (m_left == 0 && bus.req[(m_rr + k) % N]) begin
                    m_win  = (m_rr + k) % N;
                    m_left = STEPS + 1;
                end
            end
        end else if (m_left > 1) begin
            m_lfsr = lfsr_next(m_lfsr);
            m_left--;
        end else begin
            if (bus.req[m_win]) begin
                m_last = m_lfsr;
                m_rr   = (m_win + 1) % N;
            end
            m_left = 0;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_clock();
        #1;
    endtask

    task automatic check_model(input string name);
        logic [3:0]  g;
        logic [14:0] exp_v;
        logic [14:0] act_v;
        @(negedge Clk);
        g     = model_gnt();
        exp_v = {g, g != 0, (g != 0) ? m_lfsr : m_last, m_left != 0};
        act_v = {bus.gnt, bus.rand_valid, bus.rand_out, bus.busy};
        check(name, 32'(act_v), 32'(exp_v));
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        bus.en  = 1'b0;
        bus.req = '0;
`ifdef RNG_RESEED_EN
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
`endif
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        string      name;
        logic [3:0] req;
        int         stall_at;
        int         stall_len;
        int         drop_at;
        logic [3:0] exp_gnt;
        int         exp_cycle;
        logic [8:0] exp_rand;
    } vec_t;

    task automatic run_vec(input vec_t v);
        int         got_c = -1;
        logic [3:0] got_g = '0;
        logic [8:0] got_r = '0;
        do_reset();
        bus.req = v.req;
        for (int c = 1; c <= 40; c++) begin
            bus.en = !(c >= v.stall_at && c < v.stall_at + v.stall_len);
            if (c == v.drop_at) bus.req = '0;
            @(negedge Clk);
            if (got_c < 0 && bus.gnt != 0) begin
                got_c = c;
                got_g = bus.gnt;
                got_r = bus.rand_out;
            end
            @(posedge Clk);
            #1;
        end
        check({v.name, " gnt"}, 32'(got_g), 32'(v.exp_gnt));
        check({v.name, " cycle"}, 32'(got_c), 32'(v.exp_cycle));
        if (v.exp_gnt != 0) check({v.name, " rand"}, 32'(got_r), 32'(v.exp_rand));
    endtask

    vec_t vecs[7];

    initial begin
        logic [3:0] g;
        logic [3:0] r;
        int         n;
        int         gcount;
        int         first_c;
        logic [3:0] first_g;

        bus.en  = 1'b1;
        bus.req = 4'b1111;
`ifdef RNG_RESEED_EN
        bus.seed_load = 1'b0;
        bus.seed_in   = '0;
`endif
        model_reset();

        vecs[0] = '{"single0",     4'b0001, 0,  0, 0, 4'b0001, 11, 9'h102};
        vecs[1] = '{"single2",     4'b0100, 0,  0, 0, 4'b0100, 11, 9'h102};
        vecs[2] = '{"pair13",      4'b1010, 0,  0, 0, 4'b0010, 11, 9'h102};
        vecs[3] = '{"stall5",      4'b0001, 4,  5, 0, 4'b0001, 16, 9'h102};
        vecs[4] = '{"drop",        4'b0100, 0,  0, 5, 4'b0000, -1, 9'h000};
        vecs[5] = '{"idle_stall",  4'b1000, 1,  3, 0, 4'b1000, 14, 9'h102};
        vecs[6] = '{"grant_stall", 4'b1100, 11, 2, 0, 4'b0100, 13, 9'h102};

        @(negedge Clk);
        check("reset_outputs", 32'({bus.gnt, bus.rand_valid, bus.rand_out, bus.busy}), 32'(0));
        check("reset_lfsr", 32'(l_q), 32'(SEED));
        @(posedge Clk);
        #1;
        Reset = 1'b0;

        l_load = 1'b1;
        l_val  = 9'h1FF;
        @(posedge Clk); #1;
        check("lfsr_load", 32'(l_q), 32'h1FF);
        l_load  = 1'b0;
        l_shift = 1'b1;
        @(posedge Clk); #1;
        check("lfsr_lockup", 32'(l_q), 32'h0A5);
        @(posedge Clk); #1;
        check("lfsr_shift", 32'(l_q), 32'h14B);
        l_shift = 1'b0;

        for (int i = 0; i < 7; i++) run_vec(vecs[i]);

        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b1111;
        n = 0;
        for (int c = 1; c <= 60; c++) begin
            check_model("rr_seq");
            g = bus.gnt;
            if (g != 0 && n < 4) begin
                check("rr_order", 32'(g), 32'(1 << n));
                check("rr_cycle", 32'(c), 32'(11 * (n + 1)));
                n++;
            end
            @(posedge Clk);
            model_clock();
            #1;
            bus.req = bus.req & ~g;
        end
        check("rr_count", 32'(n), 32'(4));

        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0100;
        gcount  = 0;
        first_c = -1;
        first_g = '0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 5) bus.req = '0;
            if (c == 15) bus.req = 4'b1010;
            check_model("drop_seq");
            if (c < 15 && bus.gnt != 0) gcount++;
            if (c >= 15 && first_c < 0 && bus.gnt != 0) begin
                first_c = c;
                first_g = bus.gnt;
            end
            tick();
        end
        check("drop_no_gnt", 32'(gcount), 32'(0));
        check("drop_rr_kept", 32'(first_g), 32'(4'b0010));
        check("drop_next_cycle", 32'(first_c), 32'(25));

        for (int a = 0; a < 2; a++) begin
            int abort_at = (a == 0) ? 5 : 11;
            do_reset();
            bus.en  = 1'b1;
            bus.req = 4'b0001;
            for (int c = 1; c < abort_at; c++) tick();
            #2;
            Reset = 1'b1;
            #1;
            check("abort_async", 32'({bus.busy, bus.gnt, bus.rand_valid}), 32'(0));
            gcount = 0;
            for (int c = 0; c < 12; c++) begin
                @(negedge Clk);
                if (bus.gnt != 0 || bus.rand_valid) gcount++;
            end
            check("abort_hold", 32'(gcount), 32'(0));
        end

`ifdef RNG_RESEED_EN
        do_reset();
        bus.en  = 1'b1;
        bus.req = 4'b0001;
        for (int c = 1; c < 5; c++) tick();
        bus.seed_load = 1'b1;
        bus.seed_in   = 9'h123;
        @(negedge Clk);
        check("reseed_no_gnt", 32'({bus.gnt, bus.rand_valid}), 32'(0));
        @(posedge Clk); #1;
        bus.seed_load = 1'b0;
        @(negedge Clk);
        check("reseed_idle", 32'(bus.busy), 32'(0));
        first_c = -1;
        for (int c = 1; c <= 30; c++) begin
            if (c > 1) @(negedge Clk);
            if (first_c < 0 && bus.gnt != 0) begin
                first_c = c;
                check("reseed_rand", 32'(bus.rand_out), 32'(lfsr_adv(9'h123, STEPS)));
            end
            @(posedge Clk); #1;
        end
        check("reseed_cycle", 32'(first_c), 32'(11));
`endif

        do_reset();
        g = '0;
        for (int it = 0; it < 3000; it++) begin
            if (it == 1500) do_reset();
            bus.en = ($urandom_range(0, 9) != 0);
            r = bus.req & ~g;
            for (int b = 0; b < N; b++) begin
                if (r[b] && $urandom_range(0, 47) == 0) r[b] = 1'b0;
                else if (!r[b] && $urandom_range(0, 3) == 0) r[b] = 1'b1;
            end
            bus.req = r;
            check_model("random");
            g = model_gnt();
            @(posedge Clk);
            model_clock();
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/platform_rng_sched.md
PLATFORM_RNG_SCHED -- requirements
Module: platform_rng_sched

Interface
- REQ-001 Parameter N_REQ, 4, number of platform-generator requesters; legal range 2..8.
- REQ-002 Parameter STEPS, 9, LFSR shifts between consecutive grants; legal range 1..15.
- REQ-003 Parameter SEED, 9'h0A5, LFSR reset/recovery value; SHALL NOT be 9'h1FF.
- REQ-004 Clk  input  1  clock; all state changes on rising edge.
- REQ-005 Reset  input  1  reset; asynchronous, active-high.
- REQ-006 en  input  1  advance enable; when 0, FSM and LFSR hold.
- REQ-007 req  input  N_REQ  level request per requester; held until granted.
- REQ-008 gnt  output  N_REQ  one-hot grant, one-cycle pulse.
- REQ-009 rand_out  output  9  random value; valid only when rand_valid=1.
- REQ-010 rand_valid  output  1  qualifies rand_out; asserted exactly in cycles where gnt!=0.
- REQ-011 busy  output  1  high in STEP and GRANT states.
- REQ-012 seed_load, seed_in  input  1, 9  reseed strobe and value; present only under RNG_RESEED_EN.

Function
- REQ-013 FSM states: IDLE, STEP, GRANT; all transitions gated by en=1.
- REQ-014 IDLE: if any req bit is high, latch winner by round-robin, clear step counter, go to STEP; else stay.
- REQ-015 Round-robin: search starts at rr_ptr and wraps modulo N_REQ; after a grant to i, rr_ptr = (i+1) mod N_REQ.
- REQ-016 STEP: LFSR shifts once per en cycle; after STEPS shifts go to GRANT; counter width 4 bits.
- REQ-017 LFSR: 9-bit, shift toward MSB, new bit0 = ~(q[8]^q[4]); period 511.
- REQ-018 Lockup: if LFSR equals 9'h1FF, next value is SEED instead of shift.
- REQ-019 GRANT: if latched winner's req is still high, pulse gnt[winner]=1, rand_valid=1, rand_out=LFSR value; otherwise no grant and rr_ptr unchanged; then IDLE.
- REQ-020 Latency: first grant appears STEPS+2 en-cycles after req rises in IDLE.
- REQ-021 Requests rising during STEP/GRANT wait for the next IDLE arbitration.
- REQ-022 en=0 in any state freezes state, counter, LFSR and rr_ptr; gnt/rand_valid are 0 while en=0.
- REQ-023 rand_out holds last granted value outside GRANT.

Reset
- REQ-024 Reset: state=IDLE, LFSR=SEED, rr_ptr=0, counter=0, gnt=0, rand_valid=0, rand_out=0, busy=0.
- REQ-025 Reset asserted mid-STEP or mid-GRANT aborts immediately; no grant is issued.

Configuration
- REQ-026 With RNG_RESEED_EN defined: seed_load=1 loads seed_in (or SEED if seed_in==9'h1FF) into LFSR, aborts STEP/GRANT to IDLE without grant, and takes priority over en and shifting.
- REQ-027 Without RNG_RESEED_EN: seed_load/seed_in ports are absent; LFSR is seeded only by Reset and lockup recovery.

Structure
- REQ-028 Package platform_rng_pkg holds state enum, LFSR width (9), tap indices (8, 4), lockup constant 9'h1FF.
- REQ-029 LFSR is a sub-module rng_lfsr9 (ports Clk, Reset, shift, load, load_val, q); the scheduler holds the FSM and arbiter.

Verification
- REQ-030 Reset, en=1, req=4'b0001, STEPS=9 -> gnt=4'b0001 at cycle 11, rand_out = SEED shifted 9 times per REQ-017.
- REQ-031 req=4'b1111 held, each requester drops after its grant -> grant order 0,1,2,3, each STEPS+2 cycles apart.
- REQ-032 Force LFSR to 9'h1FF then shift -> next value 9'h0A5.
- REQ-033 req=4'b0100 drops mid-STEP -> no gnt, rand_valid stays 0, rr_ptr remains 0.
- REQ-034 en low for 5 cycles mid-STEP -> grant delayed exactly 5 cycles, same rand_out as no-stall run.
- REQ-035 RNG_RESEED_EN: seed_load with seed_in=9'h123 mid-STEP -> return to IDLE, no grant, LFSR=9'h123.
